// File: rtl/mux_5to1_reg.sv
// mux_5to1_reg: registered 5-to-1 selector. A 4:1 stage over a..d is combined
// with a gated e leg by a 2:1 stage on sel[2]. Codes 101/110/111 drive zero
// and raise a registered error flag.
module mux_5to1_reg #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] e,
   input  logic [2:0]       sel,
   output logic [WIDTH-1:0] out_comb,
   output logic [WIDTH-1:0] out,
   output logic             sel_err
);

   logic [WIDTH-1:0] w_stage_a;
   logic [WIDTH-1:0] w_stage_b;
   logic [WIDTH-1:0] w_sel_data;
   logic             w_low_nz;
   logic             w_sel_err;
   logic [WIDTH-1:0] r_out;
   logic             r_sel_err;

   // Stage A: 4:1 selection among a/b/c/d on the low select bits
   always_comb begin
      w_stage_a = '0;
      case (sel[1:0])
         2'b00:   w_stage_a = a;
         2'b01:   w_stage_a = b;
         2'b10:   w_stage_a = c;
         2'b11:   w_stage_a = d;
         default: w_stage_a = '0;
      endcase
   end

   // Stage B: e only when the low bits are 00, otherwise zero (invalid codes)
   always_comb begin
      w_low_nz  = sel[1] | sel[0];
      w_stage_b = w_low_nz ? '0 : e;
   end

   // Final 2:1 on sel[2] and the error decode for codes 101/110/111
   always_comb begin
      w_sel_data = sel[2] ? w_stage_b : w_stage_a;
      w_sel_err  = sel[2] & w_low_nz;
   end

   // Capture selection and error flag on enabled edges; async clear on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out     <= '0;
         r_sel_err <= 1'b0;
      end else if (en) begin
         r_out     <= w_sel_data;
         r_sel_err <= w_sel_err;
      end
   end

   assign out_comb = w_sel_data;
   assign out      = r_out;
   assign sel_err  = r_sel_err;

endmodule

// File: tb/tb_mux_5to1_reg.sv
// tb_mux_5to1_reg: directed-vector bench for mux_5to1_reg at WIDTH=4.
module tb_mux_5to1_reg;

   localparam int unsigned WIDTH = 4;
   localparam logic [WIDTH-1:0] ONES = '1;

   logic             clk;
   logic             rst_n;
   logic             en;
   logic [WIDTH-1:0] a, b, c, d, e;
   logic [2:0]       sel;
   logic [WIDTH-1:0] out_comb;
   logic [WIDTH-1:0] out;
   logic             sel_err;

   logic [WIDTH-1:0] legs [5];
   logic [WIDTH-1:0] vals [5];

   int n_checks = 0;
   int n_errors = 0;

   mux_5to1_reg #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .a        (a),
      .b        (b),
      .c        (c),
      .d        (d),
      .e        (e),
      .sel      (sel),
      .out_comb (out_comb),
      .out      (out),
      .sel_err  (sel_err)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence ever stalls
   initial begin
      #100000;
      $display("FAIL watchdog: sequence did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic apply_legs();
      a = legs[0];
      b = legs[1];
      c = legs[2];
      d = legs[3];
      e = legs[4];
   endtask

   task automatic set_all(input logic [WIDTH-1:0] v);
      for (int k = 0; k < 5; k++) legs[k] = v;
   endtask

   // Advance to 1 ns after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      sel   = 3'b000;
      a = '0; b = '0; c = '0; d = '0; e = '0;
      #2;
      check("reset_out", 32'(out), 32'h0);
      check("reset_err", 32'(sel_err), 32'h0);
      #10;
      rst_n = 1'b1;
      tick();

      // One-hot walk over valid codes
      en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         set_all('0);
         legs[i] = ONES;
         apply_legs();
         sel = 3'(i);
         #1;
         check($sformatf("onehot_comb_%0d", i), 32'(out_comb), 32'(ONES));
         tick();
         check($sformatf("onehot_out_%0d", i), 32'(out), 32'(ONES));
         check($sformatf("onehot_err_%0d", i), 32'(sel_err), 32'h0);
      end

      // All-zero data
      for (int i = 0; i < 5; i++) begin
         set_all('0);
         apply_legs();
         sel = 3'(i);
         #1;
         check($sformatf("zero_comb_%0d", i), 32'(out_comb), 32'h0);
         tick();
         check($sformatf("zero_out_%0d", i), 32'(out), 32'h0);
      end

      // Complement walk: selected leg 0, others all ones
      for (int i = 0; i < 5; i++) begin
         set_all(ONES);
         legs[i] = '0;
         apply_legs();
         sel = 3'(i);
         #1;
         check($sformatf("compl_comb_%0d", i), 32'(out_comb), 32'h0);
         tick();
         check($sformatf("compl_out_%0d", i), 32'(out), 32'h0);
      end

      // Distinct per-leg values
      vals[0] = 4'h3; vals[1] = 4'h5; vals[2] = 4'h9; vals[3] = 4'hA; vals[4] = 4'hC;
      for (int k = 0; k < 5; k++) legs[k] = vals[k];
      apply_legs();
      sel = 3'b000; #1; check("dist_comb_a", 32'(out_comb), 32'h3);
      sel = 3'b001; #1; check("dist_comb_b", 32'(out_comb), 32'h5);
      sel = 3'b010; #1; check("dist_comb_c", 32'(out_comb), 32'h9);
      sel = 3'b011; #1; check("dist_comb_d", 32'(out_comb), 32'hA);
      sel = 3'b100; #1; check("dist_comb_e", 32'(out_comb), 32'hC);
      tick();
      check("dist_out_e", 32'(out), 32'hC);

      // Invalid codes with all legs high
      set_all(ONES);
      apply_legs();
      for (int i = 5; i < 8; i++) begin
         sel = 3'(i);
         #1;
         check($sformatf("inv_comb_%0d", i), 32'(out_comb), 32'h0);
         tick();
         check($sformatf("inv_out_%0d", i), 32'(out), 32'h0);
         check($sformatf("inv_err_%0d", i), 32'(sel_err), 32'h1);
      end
      set_all('0);
      legs[0] = ONES;
      apply_legs();
      sel = 3'b000;
      tick();
      check("inv_recover_err", 32'(sel_err), 32'h0);
      check("inv_recover_out", 32'(out), 32'(ONES));

      // Enable/hold
      en = 1'b0;
      sel = 3'b001;
      b = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("hold_out_%0d", i), 32'(out), 32'(ONES));
      end
      en = 1'b1;
      tick();
      check("hold_release_out", 32'(out), 32'h0);

      // Error flag holds with enable low
      sel = 3'b110;
      tick();
      check("errhold_set", 32'(sel_err), 32'h1);
      en  = 1'b0;
      sel = 3'b000;
      tick();
      check("errhold_keep", 32'(sel_err), 32'h1);

      // Async reset clears error flag between edges
      rst_n = 1'b0;
      #1;
      check("areset_err", 32'(sel_err), 32'h0);
      check("areset_comb", 32'(out_comb), 32'(ONES));
      #5;
      rst_n = 1'b1;

      // Capture ones, then async reset clears out between edges
      en = 1'b1;
      tick();
      check("pre_reset_out", 32'(out), 32'(ONES));
      rst_n = 1'b0;
      #1;
      check("areset_out", 32'(out), 32'h0);
      tick();
      check("reset_hold_out", 32'(out), 32'h0);
      en = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();
      check("post_reset_noen", 32'(out), 32'h0);
      en = 1'b1;
      tick();
      check("post_reset_cap", 32'(out), 32'(ONES));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
